pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage ARM pipeline. It drives the per-stage enable and bubble inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the ID-stage operand forwarding selects. A small FSM freezes the whole pipeline while the data memory is not ready, and latches a sticky timeout error.

Parameters:
MAX_WAIT, 16, maximum frozen cycles on a pending memory access before timeout (>=2)
CNT_W, 16, width of the wait counter and the optional performance counters

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
id_rn, id_rm  in  4  ID-stage source register numbers
id_rn_valid, id_rm_valid  in  1  source operand actually read
ex_rd / mem_rd / wb_rd  in  4  destination register in EX / MEM / WB
ex_reg_write / mem_reg_write / wb_reg_write  in  1  stage writes its rd
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX
mem_access  in  1  MEM stage has a load/store in flight
mem_ready  in  1  data memory completes the access this cycle
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register enables
if_id_flush, id_ex_flush  out  1  insert bubble (NOP control) into register
fwd_a_sel, fwd_b_sel  out  2  00 regfile, 01 EX, 10 MEM, 11 WB
stall_active  out  1  any enable deasserted this cycle
mem_timeout  out  1  sticky error
stall_cycles, flush_count  out  CNT_W  performance counters (optional)

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Reset (async, reset=0) gives RUN, wait_cnt=0, mem_timeout=0, counters=0. Combinational outputs then take their RUN values.
- All stage outputs are combinational from the state and current inputs (zero-latency). Only state, wait_cnt, mem_timeout and the counters are registered.
- Forwarding, per operand: match means valid, rd equals the source, and the source is not 15. Priority: EX (ex_reg_write and not ex_mem_read), then MEM, then WB, else 00. R15 is never forwarded. In ERROR, forwarding selects are 00.
- Freeze: applies in RUN when mem_access=1 and mem_ready=0, and whenever the state is MEM_WAIT with mem_ready=0.
  - All five enables are 0 and both flushes are 0.
  - wait_cnt increments at each edge.
  - RUN goes to MEM_WAIT.
- MEM_WAIT with mem_ready=1: all enables 1, go to RUN, wait_cnt cleared. Load-use and branch logic apply that cycle as in RUN.
- Timeout: in MEM_WAIT, mem_ready=0 and wait_cnt==MAX_WAIT-1 at the edge gives ERROR. The error fires after exactly MAX_WAIT frozen cycles.
- ERROR: all enables 0, mem_timeout=1. The state is held until reset.
- Load-use (RUN, not frozen): ex_mem_read and ex_rd matches a valid ID source. Then pc_en=0, if_id_en=0, id_ex_flush=1, and the downstream enables stay 1. Lasts one cycle; next cycle the load is in MEM and the MEM path forwards it.
- Branch (RUN, not frozen): ex_branch_taken gives if_id_flush=1 and id_ex_flush=1 with all enables 1. A branch overrides a simultaneous load-use, so no stall.
- Simultaneous freeze and branch: the freeze wins. The branch stays in the frozen EX and the flush occurs in the release cycle.
- stall_active = not (all enables 1).
- Reset mid-wait: immediate return to RUN and the pipeline unfreezes.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments each cycle pc_en=0; flush_count increments each cycle if_id_flush=1. Both saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Package hazard_pkg holds: state enum (RUN/MEM_WAIT/ERROR), FWD_RF/FWD_EX/FWD_MEM/FWD_WB 2-bit constants, REG_PC=4'd15.
- Sub-module hazard_fwd_sel: purely combinational, one source operand to a 2-bit select. Instantiated twice (rn, rm).

Test Plan:
- id_rn=3 valid, ex_rd=3, ex_reg_write=1 and mem_rd=3, mem_reg_write=1 -> fwd_a_sel=01; id_rn=15 with the same matches -> 00.
- ex_mem_read=1, ex_rd=5, id_rm=5 valid -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle (load in MEM, mem_rd=5) fwd_b_sel=10, no stall.
- ex_branch_taken=1 together with the load-use condition -> if_id_flush=1, id_ex_flush=1, all enables 1; flush_count +1 (macro on).
- mem_access=1, mem_ready low 3 cycles then high (MAX_WAIT=16) -> enables 0 for 3 cycles, 1 in the ready cycle, state RUN, stall_cycles=3.
- MAX_WAIT=4, mem_ready held 0 -> mem_timeout=1 after the 4th frozen edge, held; assert reset=0 -> RUN, mem_timeout=0, counters 0.
- mem_access=1, mem_ready=0 with ex_branch_taken=1 -> no flush while frozen; flushes asserted in the mem_ready release cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, forwarding select codes and the operand match helper.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hazard_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   localparam logic [3:0] REG_PC = 4'd15;

   // The PC is supplied by the pipeline itself, so a write to R15 never counts as a producer.
   function automatic logic src_match(input logic       valid,
                                      input logic [3:0] src,
                                      input logic [3:0] rd);
      return valid && (src == rd) && (src != REG_PC);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one ID-stage source operand.
// Picks the youngest in-flight producer; a load still in EX cannot forward yet.
module hazard_fwd_sel
   import hazard_pkg::*;
(
   input  logic [3:0] src,
   input  logic       src_valid,
   input  logic [3:0] ex_rd,
   input  logic       ex_reg_write,
   input  logic       ex_mem_read,
   input  logic [3:0] mem_rd,
   input  logic       mem_reg_write,
   input  logic [3:0] wb_rd,
   input  logic       wb_reg_write,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_RF;
      if (ex_reg_write && !ex_mem_read && src_match(src_valid, src, ex_rd)) begin
         sel = FWD_EX;
      end else if (mem_reg_write && src_match(src_valid, src, mem_rd)) begin
         sel = FWD_MEM;
      end else if (wb_reg_write && src_match(src_valid, src, wb_rd)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline with a memory-wait freeze FSM.
// Define HAZARD_PERF_CNT_EN to build the stall_cycles / flush_count performance counters.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       id_rn,
   input  logic [3:0]       id_rm,
   input  logic             id_rn_valid,
   input  logic             id_rm_valid,
   input  logic [3:0]       ex_rd,
   input  logic [3:0]       mem_rd,
   input  logic [3:0]       wb_rd,
   input  logic             ex_reg_write,
   input  logic             mem_reg_write,
   input  logic             wb_reg_write,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall_active,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   hazard_state_t    state;
   hazard_state_t    state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_next;
   logic             frozen;
   logic             halted;
   logic             load_use;
   logic [1:0]       fwd_a_raw;
   logic [1:0]       fwd_b_raw;

   hazard_fwd_sel u_fwd_a (
      .src           (id_rn),
      .src_valid     (id_rn_valid),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .sel           (fwd_a_raw)
   );

   hazard_fwd_sel u_fwd_b (
      .src           (id_rm),
      .src_valid     (id_rm_valid),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .sel           (fwd_b_raw)
   );

   assign load_use = ex_mem_read &&
                     (src_match(id_rn_valid, id_rn, ex_rd) || src_match(id_rm_valid, id_rm, ex_rd));

   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      frozen        = 1'b0;
      halted        = 1'b0;
      case (state)
         RUN: begin
            if (mem_access && !mem_ready) begin
               frozen        = 1'b1;
               state_next    = MEM_WAIT;
               wait_cnt_next = wait_cnt + CNT_W'(1);
            end else begin
               wait_cnt_next = '0;
            end
         end
         MEM_WAIT: begin
            if (!mem_ready) begin
               frozen        = 1'b1;
               wait_cnt_next = wait_cnt + CNT_W'(1);
               if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                  state_next = ERROR;
               end
            end else begin
               state_next    = RUN;
               wait_cnt_next = '0;
            end
         end
         ERROR: begin
            halted = 1'b1;
         end
         default: begin
            state_next    = RUN;
            wait_cnt_next = '0;
         end
      endcase
   end

   // A freeze outranks a taken branch; the branch waits in EX and flushes on release.
   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (frozen || halted) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   assign fwd_a_sel    = halted ? FWD_RF : fwd_a_raw;
   assign fwd_b_sel    = halted ? FWD_RF : fwd_b_raw;
   assign stall_active = !(pc_en && if_id_en && id_ex_en && ex_mem_en && mem_wb_en);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_next;
         wait_cnt    <= wait_cnt_next;
         mem_timeout <= mem_timeout || (state_next == ERROR);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (if_id_flush && (flush_count != '1)) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
